conv_scheduler: RTL

- Sequencing controller for the 4x4 convolution MAC datapath.
- Loads the kernel from kernel memory into the datapath's kernel register file.
- Then walks the output windows across a stored source image at a programmable stride. It issues source read addresses, MAC enables and clear/last strobes, and hands each finished output off through a valid/ready handshake.
- Sits between the NPU command decoder (start/base/stride) and the conv MAC + SRAM read ports.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_window_ctr.sv | 71 +++++++
 rtl/conv_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the 4x4 convolution scheduler.
package conv_pkg;

    // Kernel edge and the number of taps per output window
    localparam int unsigned KER_EDGE = 4;
    localparam int unsigned KER_TAPS = KER_EDGE * KER_EDGE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KER,
        CALC,
        DRAIN,
        WAIT_OUT,
        DONE
    } conv_state_t;

    // Number of window positions along one image axis; 0 for an illegal stride
    function automatic int unsigned conv_out_dim(input int unsigned img,
                                                 input int unsigned k,
                                                 input logic [2:0]  stride);
        int unsigned s;
        s = {29'd0, stride};
        if (s == 0 || img < k) return 0;
        return (img - k) / s + 1;
    endfunction

endpackage

// File: rtl/conv_window_ctr.sv
// Nested tap (kx fastest, then ky) and window (ox fastest, then oy) counters.
// Window origins advance by the stride so no multiply is needed per tap.
module conv_window_ctr
    import conv_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_tap_step,
    input  logic          i_win_step,
    input  logic [2:0]    i_stride,
    input  logic [AW-1:0] i_ow,
    input  logic [AW-1:0] i_oh,
    output logic [3:0]    o_tap_idx,
    output logic [AW-1:0] o_px,
    output logic [AW-1:0] o_py,
    output logic          o_tap_first,
    output logic          o_tap_last,
    output logic          o_win_last
);

    logic [3:0]    tap_q;
    logic [AW-1:0] ox_q;
    logic [AW-1:0] oy_q;
    logic [AW-1:0] ox_org_q;
    logic [AW-1:0] oy_org_q;
    logic [AW-1:0] stride_w;
    logic          row_end;

    assign stride_w = AW'(i_stride);
    assign row_end  = (ox_q == i_ow - AW'(1));

    // Tap counter: kx lives in bits [1:0], ky in bits [3:2]; wraps after 16 taps
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            tap_q <= '0;
        end else if (i_tap_step) begin
            tap_q <= tap_q + 4'd1;
        end
    end

    // Window counter and pixel origins, stepped once per accepted output
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            ox_q     <= '0;
            oy_q     <= '0;
            ox_org_q <= '0;
            oy_org_q <= '0;
        end else if (i_win_step) begin
            if (row_end) begin
                ox_q     <= '0;
                ox_org_q <= '0;
                oy_q     <= oy_q + AW'(1);
                oy_org_q <= oy_org_q + stride_w;
            end else begin
                ox_q     <= ox_q + AW'(1);
                ox_org_q <= ox_org_q + stride_w;
            end
        end
    end

    assign o_tap_idx   = tap_q;
    assign o_px        = ox_org_q + AW'(tap_q[1:0]);
    assign o_py        = oy_org_q + AW'(tap_q[3:2]);
    assign o_tap_first = (tap_q == 4'd0);
    assign o_tap_last  = (tap_q == 4'(KER_TAPS - 1));
    assign o_win_last  = row_end && (oy_q == i_oh - AW'(1));

endmodule

// File: rtl/conv_scheduler.sv
// Sequencing controller for the 4x4 convolution MAC datapath: loads the kernel,
// then walks output windows over the source image and hands each result off.
// Optional macro CONV_SCHED_PERF_EN adds o_stall_cnt (cycles stalled on i_out_ready).
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int K     = 4,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_src_base,
    input  logic [AW-1:0] i_ker_base,
    input  logic [2:0]    i_stride,
    output logic          o_ker_rd,
    output logic [AW-1:0] o_ker_addr,
    output logic          o_ker_we,
    output logic [3:0]    o_ker_idx,
    output logic          o_src_rd,
    output logic [AW-1:0] o_src_addr,
    output logic          o_mac_en,
    output logic          o_mac_clr,
    output logic          o_mac_last,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [AW-1:0] o_out_idx,
    output logic          o_busy,
    output logic          o_done,
`ifdef CONV_SCHED_PERF_EN
    output logic [31:0]   o_stall_cnt,
`endif
    output logic          o_err
);

    conv_state_t   state_q;
    conv_state_t   state_d;
    logic [AW-1:0] src_base_q;
    logic [AW-1:0] ker_base_q;
    logic [2:0]    stride_q;
    logic [AW-1:0] ow_q;
    logic [AW-1:0] oh_q;
    logic [AW-1:0] out_idx_q;
    logic          calc_phase_q;

    logic          start_ok;
    logic          start_bad;
    logic          handshake;
    logic          ker_rd_p0;
    logic          src_rd_p0;
    logic [AW-1:0] src_addr_p0;

    logic [3:0]    tap_idx;
    logic [AW-1:0] px;
    logic [AW-1:0] py;
    logic          tap_first;
    logic          tap_last;
    logic          win_last;

    logic          ker_we_p1;
    logic [3:0]    ker_idx_p1;
    logic          mac_en_p1;
    logic          mac_clr_p1;
    logic          mac_last_p1;
    logic          err_p1;

    assign start_ok  = (state_q == IDLE) && i_start && (i_stride != 3'd0);
    assign start_bad = (state_q == IDLE) && i_start && (i_stride == 3'd0);
    assign handshake = (state_q == WAIT_OUT) && i_out_ready;

    conv_window_ctr #(
        .AW (AW)
    ) u_window_ctr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (start_ok),
        .i_tap_step  (ker_rd_p0 || src_rd_p0),
        .i_win_step  (handshake),
        .i_stride    (stride_q),
        .i_ow        (ow_q),
        .i_oh        (oh_q),
        .o_tap_idx   (tap_idx),
        .o_px        (px),
        .o_py        (py),
        .o_tap_first (tap_first),
        .o_tap_last  (tap_last),
        .o_win_last  (win_last)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and read-strobe decode; DRAIN returns to CALC after the kernel load
    always_comb begin
        state_d   = state_q;
        ker_rd_p0 = 1'b0;
        src_rd_p0 = 1'b0;
        case (state_q)
            IDLE:     if (start_ok) state_d = LOAD_KER;
            LOAD_KER: begin
                ker_rd_p0 = 1'b1;
                if (tap_last) state_d = DRAIN;
            end
            CALC:     begin
                src_rd_p0 = 1'b1;
                if (tap_last) state_d = DRAIN;
            end
            DRAIN:    state_d = calc_phase_q ? WAIT_OUT : CALC;
            WAIT_OUT: if (i_out_ready) state_d = win_last ? DONE : CALC;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Command capture of the base addresses on an accepted start
    always_ff @(posedge i_clk) begin
        if (start_ok) begin
            src_base_q <= i_src_base;
            ker_base_q <= i_ker_base;
        end
    end

    // Job control: stride, output grid size, phase flag and output index
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stride_q     <= '0;
            ow_q         <= '0;
            oh_q         <= '0;
            out_idx_q    <= '0;
            calc_phase_q <= 1'b0;
        end else if (start_ok) begin
            stride_q     <= i_stride;
            ow_q         <= AW'(conv_out_dim(IMG_W, K, i_stride));
            oh_q         <= AW'(conv_out_dim(IMG_H, K, i_stride));
            out_idx_q    <= '0;
            calc_phase_q <= 1'b0;
        end else begin
            if (state_q == CALC) calc_phase_q <= 1'b1;
            if (handshake)       out_idx_q    <= out_idx_q + AW'(1);
        end
    end

    assign src_addr_p0 = src_base_q + py * AW'(IMG_W) + px;

    // ---- stage p0 -> p1: memory read latency, write/MAC strobes follow reads by one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ker_we_p1   <= 1'b0;
            ker_idx_p1  <= '0;
            mac_en_p1   <= 1'b0;
            mac_clr_p1  <= 1'b0;
            mac_last_p1 <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            ker_we_p1   <= ker_rd_p0;
            ker_idx_p1  <= (ker_rd_p0 || src_rd_p0) ? tap_idx : 4'd0;
            mac_en_p1   <= src_rd_p0;
            mac_clr_p1  <= src_rd_p0 && tap_first;
            mac_last_p1 <= src_rd_p0 && tap_last;
            err_p1      <= start_bad;
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles the finished output waits on downstream
    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            stall_cnt_q <= '0;
        end else if ((state_q == WAIT_OUT) && !i_out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

    assign o_ker_rd    = ker_rd_p0;
    assign o_ker_addr  = ker_rd_p0 ? (ker_base_q + AW'(tap_idx)) : '0;
    assign o_ker_we    = ker_we_p1;
    assign o_ker_idx   = ker_idx_p1;
    assign o_src_rd    = src_rd_p0;
    assign o_src_addr  = src_rd_p0 ? src_addr_p0 : '0;
    assign o_mac_en    = mac_en_p1;
    assign o_mac_clr   = mac_clr_p1;
    assign o_mac_last  = mac_last_p1;
    assign o_out_valid = (state_q == WAIT_OUT);
    assign o_out_idx   = out_idx_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_err       = err_p1;

endmodule
